// File: rtl/tetris_pkg.sv
// Shared definitions for the game-logic blocks.
//   - Board geometry defaults and coordinate/rotation widths.
//   - State encoding for the move arbiter FSM.
//   - Request-kind bit positions used in the pending/grant vectors.
package tetris_pkg;

  localparam int BOARD_W_DEF = 10;
  localparam int BOARD_H_DEF = 20;
  localparam int ROT_MOD_DEF = 4;
  localparam int CHK_TIMEOUT_DEF = 15;

  localparam int COORD_W = 5;
  localparam int ROT_W   = 3;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_LOCKED = 2'd2;

  // Bit positions in the request/pending/grant vectors.
  localparam int REQ_GRAV  = 0;
  localparam int REQ_ROT   = 1;
  localparam int REQ_LEFT  = 2;
  localparam int REQ_RIGHT = 3;
  localparam int REQ_N     = 4;

endpackage

// File: rtl/move_arbiter_req_latch.sv
// req_latch: pending-request register with fixed-priority one-hot grant.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   capture_en   request pulses are latched only while high
//   clear        drops every pending bit (spawn, game not in fall state)
//   grant_en     arbitration allowed this cycle (arbiter idle)
//   req          request pulses, indexed by REQ_*
//   grant        one-hot grant, gravity > rotate > left > right
module req_latch
  import tetris_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             capture_en,
  input  logic             clear,
  input  logic             grant_en,
  input  logic [REQ_N-1:0] req,
  output logic [REQ_N-1:0] grant
);

  logic [REQ_N-1:0] pend_q;
  logic [REQ_N-1:0] drop;
  logic             lr_conflict;

  assign lr_conflict = pend_q[REQ_LEFT] & pend_q[REQ_RIGHT];

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    grant = '0;
    drop  = '0;
    if (grant_en) begin
      // Opposite horizontal moves cancel each other without a result pulse.
      if (lr_conflict) begin
        drop[REQ_LEFT]  = 1'b1;
        drop[REQ_RIGHT] = 1'b1;
      end
      if (pend_q[REQ_GRAV])
        grant[REQ_GRAV] = 1'b1;
      else if (pend_q[REQ_ROT])
        grant[REQ_ROT] = 1'b1;
      else if (pend_q[REQ_LEFT] && !lr_conflict)
        grant[REQ_LEFT] = 1'b1;
      else if (pend_q[REQ_RIGHT] && !lr_conflict)
        grant[REQ_RIGHT] = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pend_q <= '0;
    else if (clear)
      pend_q <= '0;
    else
      pend_q <= (pend_q & ~(grant | drop)) | (capture_en ? req : '0);
  end

endmodule

// File: rtl/move_arbiter.sv
// move_arbiter: latches move requests, grants one at a time, sends the
// candidate position to the shared collision checker and commits or rejects
// it on the result. Owns the authoritative piece position and rotation.
// Ports:
//   CLOCK_50, resetn                  clock, asynchronous active-low reset
//   enable                            game in fall state; gates capture
//   left_final/right_final/rot_final/tick_gravity   request pulses
//   spawn, spawn_x, spawn_y           load a new piece (highest precedence)
//   cand_x/cand_y/cand_rot, chk_valid candidate to checker, held until done
//   chk_done, chk_collide             checker result
//   piece_x/piece_y/rot               committed piece state
//   move_accept/move_reject/lock_req  one-cycle result pulses
//   locked                            high from lock until next spawn
//   chk_err                           sticky checker-timeout flag
module move_arbiter
  import tetris_pkg::*;
#(
  parameter int BOARD_W     = BOARD_W_DEF,
  parameter int BOARD_H     = BOARD_H_DEF,
  parameter int ROT_MOD     = ROT_MOD_DEF,
  parameter int CHK_TIMEOUT = CHK_TIMEOUT_DEF
) (
  input  logic               CLOCK_50,
  input  logic               resetn,
  input  logic               enable,
  input  logic               left_final,
  input  logic               right_final,
  input  logic               rot_final,
  input  logic               tick_gravity,
  input  logic               spawn,
  input  logic [COORD_W-1:0] spawn_x,
  input  logic [COORD_W-1:0] spawn_y,
  output logic [COORD_W-1:0] cand_x,
  output logic [COORD_W-1:0] cand_y,
  output logic [ROT_W-1:0]   cand_rot,
  output logic               chk_valid,
  input  logic               chk_done,
  input  logic               chk_collide,
  output logic [COORD_W-1:0] piece_x,
  output logic [COORD_W-1:0] piece_y,
  output logic [ROT_W-1:0]   rot,
  output logic               move_accept,
  output logic               move_reject,
  output logic               lock_req,
  output logic               locked,
  output logic               chk_err
);

  localparam int TMR_W = $clog2(CHK_TIMEOUT + 1);
  localparam logic [COORD_W-1:0] X_LAST  = COORD_W'(BOARD_W - 1);
  localparam logic [COORD_W-1:0] Y_LAST  = COORD_W'(BOARD_H - 1);
  localparam logic [COORD_W-1:0] X_RESET = COORD_W'(BOARD_W / 2);
  localparam logic [ROT_W-1:0]   R_LAST  = ROT_W'(ROT_MOD - 1);
  localparam logic [TMR_W-1:0]   T_LAST  = TMR_W'(CHK_TIMEOUT - 1);

  logic [1:0]       state;
  logic [TMR_W-1:0] timer;
  logic             cur_grav;
  logic [REQ_N-1:0] req;
  logic [REQ_N-1:0] grant;

  logic [COORD_W-1:0] nx, ny;
  logic [ROT_W-1:0]   nr;
  logic               launch, pre_reject, pre_lock;

  assign locked = (state == S_LOCKED);

  assign req[REQ_GRAV]  = tick_gravity;
  assign req[REQ_ROT]   = rot_final;
  assign req[REQ_LEFT]  = left_final;
  assign req[REQ_RIGHT] = right_final;

  req_latch u_req_latch (
    .clk        (CLOCK_50),
    .rst_n      (resetn),
    .capture_en (enable & ~locked),
    .clear      (spawn | ~enable),
    .grant_en   ((state == S_IDLE) & ~spawn),
    .req        (req),
    .grant      (grant)
  );

  // Candidate for the granted move; boundary cases are resolved here so no
  // wrapped coordinate ever reaches the checker.
  always_comb begin
    nx         = piece_x;
    ny         = piece_y;
    nr         = rot;
    launch     = 1'b0;
    pre_reject = 1'b0;
    pre_lock   = 1'b0;
    if (grant[REQ_GRAV]) begin
      if (piece_y == Y_LAST) pre_lock = 1'b1;
      else begin ny = piece_y + 1'b1; launch = 1'b1; end
    end else if (grant[REQ_ROT]) begin
      nr     = (rot == R_LAST) ? '0 : rot + 1'b1;
      launch = 1'b1;
    end else if (grant[REQ_LEFT]) begin
      if (piece_x == '0) pre_reject = 1'b1;
      else begin nx = piece_x - 1'b1; launch = 1'b1; end
    end else if (grant[REQ_RIGHT]) begin
      if (piece_x == X_LAST) pre_reject = 1'b1;
      else begin nx = piece_x + 1'b1; launch = 1'b1; end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state       <= S_IDLE;
      timer       <= '0;
      cur_grav    <= 1'b0;
      cand_x      <= '0;
      cand_y      <= '0;
      cand_rot    <= '0;
      chk_valid   <= 1'b0;
      piece_x     <= X_RESET;
      piece_y     <= '0;
      rot         <= '0;
      move_accept <= 1'b0;
      move_reject <= 1'b0;
      lock_req    <= 1'b0;
      chk_err     <= 1'b0;
    end else begin
      move_accept <= 1'b0;
      move_reject <= 1'b0;
      lock_req    <= 1'b0;
      if (spawn) begin
        // Aborts any in-flight check; a coincident chk_done is ignored.
        piece_x   <= spawn_x;
        piece_y   <= spawn_y;
        rot       <= '0;
        chk_valid <= 1'b0;
        timer     <= '0;
        state     <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (launch) begin
              cand_x    <= nx;
              cand_y    <= ny;
              cand_rot  <= nr;
              cur_grav  <= grant[REQ_GRAV];
              chk_valid <= 1'b1;
              timer     <= '0;
              state     <= S_WAIT;
            end else if (pre_reject) begin
              move_reject <= 1'b1;
            end else if (pre_lock) begin
              lock_req <= 1'b1;
              state    <= S_LOCKED;
            end
          end
          S_WAIT: begin
            // A silent checker is treated as a collision on its last cycle.
            if (chk_done || timer == T_LAST) begin
              chk_valid <= 1'b0;
              if (!chk_done) chk_err <= 1'b1;
              if (chk_done && !chk_collide) begin
                piece_x     <= cand_x;
                piece_y     <= cand_y;
                rot         <= cand_rot;
                move_accept <= 1'b1;
                state       <= S_IDLE;
              end else if (cur_grav) begin
                lock_req <= 1'b1;
                state    <= S_LOCKED;
              end else begin
                move_reject <= 1'b1;
                state       <= S_IDLE;
              end
            end else begin
              timer <= timer + 1'b1;
            end
          end
          S_LOCKED: ;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_move_arbiter.sv
// Directed self-checking bench for move_arbiter. Inputs are driven and
// outputs sampled 1 ns after each rising edge.
module tb_move_arbiter;
  import tetris_pkg::*;

  logic               CLOCK_50 = 1'b0;
  logic               resetn;
  logic               enable;
  logic               left_final, right_final, rot_final, tick_gravity;
  logic               spawn;
  logic [COORD_W-1:0] spawn_x, spawn_y;
  logic [COORD_W-1:0] cand_x, cand_y;
  logic [ROT_W-1:0]   cand_rot;
  logic               chk_valid, chk_done, chk_collide;
  logic [COORD_W-1:0] piece_x, piece_y;
  logic [ROT_W-1:0]   rot;
  logic               move_accept, move_reject, lock_req, locked, chk_err;

  int checks = 0;
  int errors = 0;

  move_arbiter dut (
    .CLOCK_50     (CLOCK_50),
    .resetn       (resetn),
    .enable       (enable),
    .left_final   (left_final),
    .right_final  (right_final),
    .rot_final    (rot_final),
    .tick_gravity (tick_gravity),
    .spawn        (spawn),
    .spawn_x      (spawn_x),
    .spawn_y      (spawn_y),
    .cand_x       (cand_x),
    .cand_y       (cand_y),
    .cand_rot     (cand_rot),
    .chk_valid    (chk_valid),
    .chk_done     (chk_done),
    .chk_collide  (chk_collide),
    .piece_x      (piece_x),
    .piece_y      (piece_y),
    .rot          (rot),
    .move_accept  (move_accept),
    .move_reject  (move_reject),
    .lock_req     (lock_req),
    .locked       (locked),
    .chk_err      (chk_err)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge CLOCK_50);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_pulses(input string tag, input logic a, input logic r, input logic l);
    check({tag, ".accept"}, 32'(move_accept), 32'(a));
    check({tag, ".reject"}, 32'(move_reject), 32'(r));
    check({tag, ".lock_req"}, 32'(lock_req), 32'(l));
  endtask

  task automatic do_spawn(input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y);
    spawn = 1'b1; spawn_x = x; spawn_y = y;
    tick();
    spawn = 1'b0;
  endtask

  task automatic rotate_ok();
    rot_final = 1'b1; tick(); rot_final = 1'b0;
    tick();
    chk_done = 1'b1; chk_collide = 1'b0; tick(); chk_done = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; enable = 1'b0;
    left_final = 1'b0; right_final = 1'b0; rot_final = 1'b0; tick_gravity = 1'b0;
    spawn = 1'b0; spawn_x = '0; spawn_y = '0;
    chk_done = 1'b0; chk_collide = 1'b0;
    tick(2);

    // Reset values
    check("rst.piece_x", 32'(piece_x), 5);
    check("rst.piece_y", 32'(piece_y), 0);
    check("rst.rot", 32'(rot), 0);
    check("rst.chk_valid", 32'(chk_valid), 0);
    check("rst.locked", 32'(locked), 0);
    check("rst.chk_err", 32'(chk_err), 0);
    check("rst.cand_x", 32'(cand_x), 0);
    check_pulses("rst", 0, 0, 0);
    resetn = 1'b1; enable = 1'b1;
    tick();

    // Left move accepted, checker answers two cycles after valid
    do_spawn(5'd4, 5'd0);
    check("spawn.piece_x", 32'(piece_x), 4);
    check("spawn.piece_y", 32'(piece_y), 0);
    left_final = 1'b1; tick(); left_final = 1'b0;
    check("lat.valid_early", 32'(chk_valid), 0);
    tick();
    check("left.valid", 32'(chk_valid), 1);
    check("left.cand_x", 32'(cand_x), 3);
    check("left.cand_y", 32'(cand_y), 0);
    check("left.cand_rot", 32'(cand_rot), 0);
    tick();
    check("left.valid_held", 32'(chk_valid), 1);
    check("left.cand_held", 32'(cand_x), 3);
    chk_done = 1'b1; chk_collide = 1'b0; tick(); chk_done = 1'b0;
    check_pulses("left.done", 1, 0, 0);
    check("left.piece_x", 32'(piece_x), 3);
    check("left.valid_drop", 32'(chk_valid), 0);
    tick();
    check("left.accept_1cyc", 32'(move_accept), 0);

    // Gravity and rotate together: gravity first, then rotate
    tick_gravity = 1'b1; rot_final = 1'b1; tick();
    tick_gravity = 1'b0; rot_final = 1'b0;
    tick();
    check("prio.grav_cand_y", 32'(cand_y), 1);
    check("prio.grav_cand_rot", 32'(cand_rot), 0);
    check("prio.grav_valid", 32'(chk_valid), 1);
    chk_done = 1'b1; tick(); chk_done = 1'b0;
    check("prio.accept1", 32'(move_accept), 1);
    check("prio.piece_y", 32'(piece_y), 1);
    tick();
    check("prio.rot_cand", 32'(cand_rot), 1);
    check("prio.rot_cand_y", 32'(cand_y), 1);
    check("prio.rot_valid", 32'(chk_valid), 1);
    check("prio.accept_gap", 32'(move_accept), 0);
    chk_done = 1'b1; tick(); chk_done = 1'b0;
    check("prio.accept2", 32'(move_accept), 1);
    check("prio.rot", 32'(rot), 1);

    // Left at the wall: pre-check reject, checker untouched
    do_spawn(5'd0, 5'd5);
    left_final = 1'b1; tick(); left_final = 1'b0;
    tick();
    check_pulses("wall_l", 0, 1, 0);
    check("wall_l.valid", 32'(chk_valid), 0);
    tick();
    check("wall_l.reject_1cyc", 32'(move_reject), 0);
    check("wall_l.valid2", 32'(chk_valid), 0);
    check("wall_l.piece_x", 32'(piece_x), 0);

    // Left and right together cancel
    left_final = 1'b1; right_final = 1'b1; tick();
    left_final = 1'b0; right_final = 1'b0;
    tick();
    check_pulses("lr", 0, 0, 0);
    check("lr.valid", 32'(chk_valid), 0);
    tick();
    check_pulses("lr2", 0, 0, 0);
    check("lr2.valid", 32'(chk_valid), 0);

    // Right move with collision -> reject
    right_final = 1'b1; tick(); right_final = 1'b0;
    tick();
    check("rcol.valid", 32'(chk_valid), 1);
    check("rcol.cand_x", 32'(cand_x), 1);
    chk_done = 1'b1; chk_collide = 1'b1; tick(); chk_done = 1'b0; chk_collide = 1'b0;
    check_pulses("rcol", 0, 1, 0);
    check("rcol.piece_x", 32'(piece_x), 0);
    check("rcol.valid_drop", 32'(chk_valid), 0);

    // Right at the right wall
    do_spawn(5'd9, 5'd0);
    right_final = 1'b1; tick(); right_final = 1'b0;
    tick();
    check_pulses("wall_r", 0, 1, 0);
    check("wall_r.valid", 32'(chk_valid), 0);

    // Blocked gravity -> lock; requests ignored until spawn
    do_spawn(5'd4, 5'd5);
    tick_gravity = 1'b1; tick(); tick_gravity = 1'b0;
    tick();
    check("lock.cand_y", 32'(cand_y), 6);
    check("lock.valid", 32'(chk_valid), 1);
    chk_done = 1'b1; chk_collide = 1'b1; tick(); chk_done = 1'b0; chk_collide = 1'b0;
    check_pulses("lock", 0, 0, 1);
    check("lock.locked", 32'(locked), 1);
    check("lock.valid_drop", 32'(chk_valid), 0);
    check("lock.piece_y", 32'(piece_y), 5);
    tick();
    check("lock.req_1cyc", 32'(lock_req), 0);
    check("lock.locked_hold", 32'(locked), 1);
    left_final = 1'b1; tick(); left_final = 1'b0;
    tick(2);
    check("lock.ign_valid", 32'(chk_valid), 0);
    check("lock.ign_piece_x", 32'(piece_x), 4);
    check_pulses("lock.ign", 0, 0, 0);
    do_spawn(5'd4, 5'd0);
    check("respawn.locked", 32'(locked), 0);
    check("respawn.piece_x", 32'(piece_x), 4);
    check("respawn.piece_y", 32'(piece_y), 0);
    check("respawn.rot", 32'(rot), 0);
    tick();
    check("respawn.valid", 32'(chk_valid), 0);

    // Gravity on the bottom row locks without the checker
    do_spawn(5'd2, 5'd19);
    tick_gravity = 1'b1; tick(); tick_gravity = 1'b0;
    tick();
    check_pulses("floor", 0, 0, 1);
    check("floor.locked", 32'(locked), 1);
    check("floor.valid", 32'(chk_valid), 0);
    check("floor.piece_y", 32'(piece_y), 19);
    do_spawn(5'd4, 5'd0);

    // Rotation wraps 3 -> 0
    rotate_ok(); rotate_ok(); rotate_ok();
    check("wrap.rot3", 32'(rot), 3);
    rot_final = 1'b1; tick(); rot_final = 1'b0;
    tick();
    check("wrap.cand_rot", 32'(cand_rot), 0);
    chk_done = 1'b1; tick(); chk_done = 1'b0;
    check("wrap.accept", 32'(move_accept), 1);
    check("wrap.rot0", 32'(rot), 0);

    // Checker silent: forced reject after 15 cycles in S_WAIT
    right_final = 1'b1; tick(); right_final = 1'b0;
    tick();
    check("to.valid", 32'(chk_valid), 1);
    check("to.cand_x", 32'(cand_x), 5);
    tick(14);
    check("to.valid_14", 32'(chk_valid), 1);
    check("to.err_14", 32'(chk_err), 0);
    tick();
    check("to.err", 32'(chk_err), 1);
    check_pulses("to", 0, 1, 0);
    check("to.valid_drop", 32'(chk_valid), 0);
    check("to.piece_x", 32'(piece_x), 4);
    tick();
    check("to.reject_1cyc", 32'(move_reject), 0);
    check("to.err_sticky", 32'(chk_err), 1);

    // Spawn during S_WAIT wins over a coincident chk_done
    left_final = 1'b1; tick(); left_final = 1'b0;
    tick();
    check("abort.valid", 32'(chk_valid), 1);
    check("abort.cand_x", 32'(cand_x), 3);
    spawn = 1'b1; spawn_x = 5'd7; spawn_y = 5'd2; chk_done = 1'b1; chk_collide = 1'b0;
    tick();
    spawn = 1'b0; chk_done = 1'b0;
    check("abort.piece_x", 32'(piece_x), 7);
    check("abort.piece_y", 32'(piece_y), 2);
    check("abort.valid_drop", 32'(chk_valid), 0);
    check_pulses("abort", 0, 0, 0);
    tick();
    check_pulses("abort2", 0, 0, 0);
    right_final = 1'b1; tick(); right_final = 1'b0;
    tick();
    check("abort.idle_valid", 32'(chk_valid), 1);
    check("abort.idle_cand_x", 32'(cand_x), 8);

    // Asynchronous reset mid-check
    #2 resetn = 1'b0;
    #1;
    check("arst.valid", 32'(chk_valid), 0);
    check("arst.piece_x", 32'(piece_x), 5);
    check("arst.piece_y", 32'(piece_y), 0);
    check("arst.chk_err", 32'(chk_err), 0);
    check("arst.cand_x", 32'(cand_x), 0);
    check("arst.locked", 32'(locked), 0);
    tick();
    resetn = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
